// File: rtl/vec_exp_collector.sv
// rtl/vec_exp_collector.sv - keeps the lowest-index exception of one vector instruction and reports trap or completion
// Optional fault-only-first vl trimming is enabled by defining FAULT_ONLY_FIRST_EN.
module vec_exp_collector #(
  parameter int NrCh     = 4,
  parameter int ElemIdxW = 16,
  parameter int XLEN     = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_valid_i,
  input  logic                       start_fof_i,
  output logic                       start_ready_o,
  input  logic [NrCh-1:0]            ch_exp_valid_i,
  input  logic [NrCh*4-1:0]          ch_exp_type_i,
  input  logic [NrCh*XLEN-1:0]       ch_exp_tval_i,
  input  logic [NrCh*ElemIdxW-1:0]   ch_exp_idx_i,
  input  logic [NrCh-1:0]            ch_done_i,
  input  logic                       flush_i,
  output logic                       rpt_valid_o,
  input  logic                       rpt_ready_i,
  output logic                       rpt_exp_o,
  output logic [3:0]                 rpt_type_o,
  output logic [XLEN-1:0]            rpt_tval_o,
  output logic [ElemIdxW-1:0]        rpt_vstart_o,
  output logic                       rpt_trim_o
);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_REPORT} state_e;

  state_e                state_q, state_d;
  logic                  rec_vld_q, rec_vld_d;
  logic [3:0]            rec_type_q, rec_type_d;
  logic [XLEN-1:0]       rec_tval_q, rec_tval_d;
  logic [ElemIdxW-1:0]   rec_idx_q, rec_idx_d;
  logic [NrCh-1:0]       done_q, done_d;
  logic                  rpt_valid_q, rpt_valid_d;
  logic                  rpt_exp_q, rpt_exp_d;
  logic [3:0]            rpt_type_q, rpt_type_d;
  logic [XLEN-1:0]       rpt_tval_q, rpt_tval_d;
  logic [ElemIdxW-1:0]   rpt_vstart_q, rpt_vstart_d;
  logic                  rpt_trim_q, rpt_trim_d;

  logic                  new_vld;
  logic [3:0]            new_type;
  logic [XLEN-1:0]       new_tval;
  logic [ElemIdxW-1:0]   new_idx;
  logic                  take_new;
  logic                  cur_vld;
  logic [3:0]            cur_type;
  logic [XLEN-1:0]       cur_tval;
  logic [ElemIdxW-1:0]   cur_idx;
  logic                  trim_hit;

  // Strict less-than in ascending channel order makes the lowest channel win same-cycle ties.
  always_comb begin
    new_vld  = 1'b0;
    new_type = '0;
    new_tval = '0;
    new_idx  = '0;
    for (int i = 0; i < NrCh; i++) begin
      if (ch_exp_valid_i[i] && !done_q[i] &&
          (!new_vld || (ch_exp_idx_i[i*ElemIdxW +: ElemIdxW] < new_idx))) begin
        new_vld  = 1'b1;
        new_type = ch_exp_type_i[i*4 +: 4];
        new_tval = ch_exp_tval_i[i*XLEN +: XLEN];
        new_idx  = ch_exp_idx_i[i*ElemIdxW +: ElemIdxW];
      end
    end
  end

  // Held record wins an index tie against a newer report.
  always_comb begin
    take_new = new_vld && (state_q == S_COLLECT) && (!rec_vld_q || (new_idx < rec_idx_q));
    cur_vld  = rec_vld_q || take_new;
    cur_type = take_new ? new_type : rec_type_q;
    cur_tval = take_new ? new_tval : rec_tval_q;
    cur_idx  = take_new ? new_idx  : rec_idx_q;
  end

`ifdef FAULT_ONLY_FIRST_EN
  logic fof_q, fof_d;

  always_comb begin
    fof_d = fof_q;
    if (state_q == S_IDLE && start_valid_i) fof_d = start_fof_i;
    if (flush_i) fof_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) fof_q <= 1'b0;
    else       fof_q <= fof_d;
  end

  assign trim_hit = fof_q && cur_vld && (cur_idx != '0);
`else
  logic unused_fof;
  assign unused_fof = start_fof_i;
  assign trim_hit   = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    rec_vld_d    = rec_vld_q;
    rec_type_d   = rec_type_q;
    rec_tval_d   = rec_tval_q;
    rec_idx_d    = rec_idx_q;
    done_d       = done_q;
    rpt_valid_d  = rpt_valid_q;
    rpt_exp_d    = rpt_exp_q;
    rpt_type_d   = rpt_type_q;
    rpt_tval_d   = rpt_tval_q;
    rpt_vstart_d = rpt_vstart_q;
    rpt_trim_d   = rpt_trim_q;

    case (state_q)
      S_IDLE: begin
        if (start_valid_i) begin
          state_d   = S_COLLECT;
          rec_vld_d = 1'b0;
          done_d    = '0;
        end
      end
      S_COLLECT: begin
        rec_vld_d  = cur_vld;
        rec_type_d = cur_type;
        rec_tval_d = cur_tval;
        rec_idx_d  = cur_idx;
        done_d     = done_q | ch_done_i;
        if (&done_d) begin
          state_d      = S_REPORT;
          rpt_valid_d  = 1'b1;
          rpt_exp_d    = cur_vld && !trim_hit;
          rpt_trim_d   = trim_hit;
          rpt_type_d   = cur_vld ? cur_type : '0;
          rpt_tval_d   = cur_vld ? cur_tval : '0;
          rpt_vstart_d = cur_vld ? cur_idx  : '0;
        end
      end
      S_REPORT: begin
        if (rpt_ready_i) begin
          state_d      = S_IDLE;
          rpt_valid_d  = 1'b0;
          rpt_exp_d    = 1'b0;
          rpt_type_d   = '0;
          rpt_tval_d   = '0;
          rpt_vstart_d = '0;
          rpt_trim_d   = 1'b0;
          rec_vld_d    = 1'b0;
          done_d       = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (flush_i) begin
      state_d      = S_IDLE;
      rec_vld_d    = 1'b0;
      rec_type_d   = '0;
      rec_tval_d   = '0;
      rec_idx_d    = '0;
      done_d       = '0;
      rpt_valid_d  = 1'b0;
      rpt_exp_d    = 1'b0;
      rpt_type_d   = '0;
      rpt_tval_d   = '0;
      rpt_vstart_d = '0;
      rpt_trim_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      rec_vld_q    <= 1'b0;
      rec_type_q   <= '0;
      rec_tval_q   <= '0;
      rec_idx_q    <= '0;
      done_q       <= '0;
      rpt_valid_q  <= 1'b0;
      rpt_exp_q    <= 1'b0;
      rpt_type_q   <= '0;
      rpt_tval_q   <= '0;
      rpt_vstart_q <= '0;
      rpt_trim_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rec_vld_q    <= rec_vld_d;
      rec_type_q   <= rec_type_d;
      rec_tval_q   <= rec_tval_d;
      rec_idx_q    <= rec_idx_d;
      done_q       <= done_d;
      rpt_valid_q  <= rpt_valid_d;
      rpt_exp_q    <= rpt_exp_d;
      rpt_type_q   <= rpt_type_d;
      rpt_tval_q   <= rpt_tval_d;
      rpt_vstart_q <= rpt_vstart_d;
      rpt_trim_q   <= rpt_trim_d;
    end
  end

  assign start_ready_o = (state_q == S_IDLE);
  assign rpt_valid_o   = rpt_valid_q;
  assign rpt_exp_o     = rpt_exp_q;
  assign rpt_type_o    = rpt_type_q;
  assign rpt_tval_o    = rpt_tval_q;
  assign rpt_vstart_o  = rpt_vstart_q;
  assign rpt_trim_o    = rpt_trim_q;

endmodule

// File: tb/tb_vec_exp_collector.sv
// tb/tb_vec_exp_collector.sv - directed self-checking bench for vec_exp_collector
module tb_vec_exp_collector;
  localparam int NrCh = 4;
  localparam int IW   = 16;
  localparam int XL   = 64;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start_valid = 1'b0;
  logic              start_fof = 1'b0;
  logic              start_ready;
  logic [NrCh-1:0]   ch_exp_valid = '0;
  logic [NrCh*4-1:0] ch_exp_type = '0;
  logic [NrCh*XL-1:0] ch_exp_tval = '0;
  logic [NrCh*IW-1:0] ch_exp_idx = '0;
  logic [NrCh-1:0]   ch_done = '0;
  logic              flush = 1'b0;
  logic              rpt_valid;
  logic              rpt_ready = 1'b0;
  logic              rpt_exp;
  logic [3:0]        rpt_type;
  logic [XL-1:0]     rpt_tval;
  logic [IW-1:0]     rpt_vstart;
  logic              rpt_trim;

  int checks = 0;
  int errors = 0;

  vec_exp_collector #(.NrCh(NrCh), .ElemIdxW(IW), .XLEN(XL)) dut (
    .clk_i(clk), .rst_i(rst),
    .start_valid_i(start_valid), .start_fof_i(start_fof), .start_ready_o(start_ready),
    .ch_exp_valid_i(ch_exp_valid), .ch_exp_type_i(ch_exp_type),
    .ch_exp_tval_i(ch_exp_tval), .ch_exp_idx_i(ch_exp_idx),
    .ch_done_i(ch_done), .flush_i(flush),
    .rpt_valid_o(rpt_valid), .rpt_ready_i(rpt_ready), .rpt_exp_o(rpt_exp),
    .rpt_type_o(rpt_type), .rpt_tval_o(rpt_tval), .rpt_vstart_o(rpt_vstart),
    .rpt_trim_o(rpt_trim)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    ch_exp_valid = '0;
    ch_done      = '0;
    start_valid  = 1'b0;
    flush        = 1'b0;
  endtask

  task automatic set_exp(input int ch, input logic [3:0] t, input logic [63:0] v, input logic [15:0] idx);
    ch_exp_valid[ch]        = 1'b1;
    ch_exp_type[ch*4 +: 4]  = t;
    ch_exp_tval[ch*XL +: XL] = v;
    ch_exp_idx[ch*IW +: IW] = idx;
  endtask

  task automatic start_instr(input logic fof);
    start_valid = 1'b1;
    start_fof   = fof;
    step();
    start_fof = 1'b0;
    chk("start_taken", start_ready, 1'b0);
  endtask

  task automatic finish_rpt();
    rpt_ready = 1'b1;
    step();
    rpt_ready = 1'b0;
    chk("ready_after_hs", start_ready, 1'b1);
    chk("valid_after_hs", rpt_valid, 1'b0);
  endtask

  task automatic chk_rpt(input string tag, input logic e, input logic [3:0] t,
                         input logic [63:0] v, input logic [15:0] idx, input logic trim);
    chk({tag, "_valid"}, rpt_valid, 1'b1);
    chk({tag, "_exp"}, rpt_exp, e);
    chk({tag, "_type"}, rpt_type, t);
    chk({tag, "_tval"}, rpt_tval, v);
    chk({tag, "_vstart"}, rpt_vstart, idx);
    chk({tag, "_trim"}, rpt_trim, trim);
  endtask

  logic [3:0] done_sched [1:9];

  initial begin
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("rst_start_ready", start_ready, 1'b1);
    chk("rst_rpt_valid", rpt_valid, 1'b0);
    chk("rst_rpt_exp", rpt_exp, 1'b0);
    chk("rst_rpt_tval", rpt_tval, 64'h0);

    // Lowest index wins across channels.
    start_instr(1'b0);
    step();
    set_exp(0, 4'd13, 64'h1000, 16'd7);
    set_exp(2, 4'd5, 64'h2230, 16'd3);
    step();
    step();
    ch_done = 4'hF;
    chk("t1_not_yet", rpt_valid, 1'b0);
    step();
    chk_rpt("t1", 1'b1, 4'd5, 64'h2230, 16'd3, 1'b0);
    finish_rpt();

    // Same-cycle tie: lower channel kept.
    start_instr(1'b0);
    set_exp(1, 4'd7, 64'hAAAA, 16'd5);
    set_exp(3, 4'd6, 64'hBBBB, 16'd5);
    ch_done = 4'hF;
    step();
    chk_rpt("tie_same", 1'b1, 4'd7, 64'hAAAA, 16'd5, 1'b0);
    finish_rpt();

    // Later tie: held record kept.
    start_instr(1'b0);
    step();
    set_exp(3, 4'd6, 64'hBBBB, 16'd5);
    step();
    step();
    set_exp(1, 4'd7, 64'hAAAA, 16'd5);
    ch_done = 4'hF;
    step();
    chk_rpt("tie_held", 1'b1, 4'd6, 64'hBBBB, 16'd5, 1'b0);
    finish_rpt();

    // Later, lower index replaces held record; exception and done together on one channel.
    start_instr(1'b0);
    set_exp(0, 4'd4, 64'h11, 16'd9);
    ch_done = 4'b0001;
    step();
    set_exp(1, 4'd2, 64'h22, 16'd2);
    ch_done = 4'b1110;
    step();
    chk_rpt("lower_later", 1'b1, 4'd2, 64'h22, 16'd2, 1'b0);
    finish_rpt();

    // Staggered done, no exceptions: dones at cycles 2,3,6,9 -> report at cycle 10.
    for (int c = 1; c <= 9; c++) done_sched[c] = 4'h0;
    done_sched[2] = 4'b0001;
    done_sched[3] = 4'b0010;
    done_sched[6] = 4'b0100;
    done_sched[9] = 4'b1000;
    start_instr(1'b0);
    for (int c = 1; c <= 9; c++) begin
      ch_done = done_sched[c];
      if (c >= 8) chk($sformatf("stagger_wait_c%0d", c), rpt_valid, 1'b0);
      step();
    end
    chk_rpt("stagger", 1'b0, 4'd0, 64'h0, 16'd0, 1'b0);

    // Stall: report held stable, no new start accepted.
    for (int k = 0; k < 5; k++) begin
      start_valid = 1'b1;
      step();
      chk($sformatf("stall_valid_%0d", k), rpt_valid, 1'b1);
      chk($sformatf("stall_sready_%0d", k), start_ready, 1'b0);
      chk($sformatf("stall_exp_%0d", k), rpt_exp, 1'b0);
    end
    finish_rpt();

    // Flush during collection drops the pending exception.
    start_instr(1'b0);
    set_exp(0, 4'd13, 64'hDEAD, 16'd1);
    step();
    flush   = 1'b1;
    ch_done = 4'hF;
    step();
    chk("flush_idle", start_ready, 1'b1);
    chk("flush_no_rpt", rpt_valid, 1'b0);
    step();
    chk("flush_still_no_rpt", rpt_valid, 1'b0);
    flush       = 1'b1;
    start_valid = 1'b1;
    step();
    chk("flush_blocks_start", start_ready, 1'b1);
    start_instr(1'b0);
    ch_done = 4'hF;
    step();
    chk_rpt("post_flush", 1'b0, 4'd0, 64'h0, 16'd0, 1'b0);
    finish_rpt();

    // Reset while a trap report is pending.
    start_instr(1'b0);
    set_exp(2, 4'd15, 64'hCAFE, 16'd8);
    ch_done = 4'hF;
    step();
    chk("pre_rst_valid", rpt_valid, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_valid", rpt_valid, 1'b0);
    chk("midrst_exp", rpt_exp, 1'b0);
    chk("midrst_type", rpt_type, 4'd0);
    chk("midrst_tval", rpt_tval, 64'h0);
    chk("midrst_sready", start_ready, 1'b1);
    start_instr(1'b0);
    ch_done = 4'hF;
    step();
    chk_rpt("post_rst", 1'b0, 4'd0, 64'h0, 16'd0, 1'b0);
    finish_rpt();

    // Fault-only-first start with a nonzero index, then with index 0.
    start_instr(1'b1);
    set_exp(1, 4'd13, 64'h4440, 16'd4);
    ch_done = 4'hF;
    step();
`ifdef FAULT_ONLY_FIRST_EN
    chk_rpt("fof_trim", 1'b0, 4'd13, 64'h4440, 16'd4, 1'b1);
`else
    chk_rpt("fof_off", 1'b1, 4'd13, 64'h4440, 16'd4, 1'b0);
`endif
    finish_rpt();
    start_instr(1'b1);
    set_exp(3, 4'd13, 64'h5550, 16'd0);
    ch_done = 4'hF;
    step();
    chk_rpt("fof_idx0", 1'b1, 4'd13, 64'h5550, 16'd0, 1'b0);
    finish_rpt();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
